// File: rtl/pe_cell_param.sv
// pe_cell_param -- parametrised registered processing element for the NPU
// systolic array.
//
// Activations move left-to-right, weights and partial sums move top-to-bottom.
// Two dataflows are selectable every cycle through `mode`:
//   WS (mode=0): the stationary weight is double-buffered (shadow/active).
//                c_out = sat(c_in + a_in*active) whenever a_in is valid.
//   OS (mode=1): the cell keeps a local accumulator fed by a_in*w_in. `drain`
//                dumps it onto c_out. Otherwise c_in/c_valid_in are forwarded
//                down the drain chain.
// Accumulation saturates to the signed ACCW range and sets the sticky `ovf`.
// err_mult / err_mac flip bit 0 of the product / clamped sum for fault studies.
//
// Parameters: DW   signed data width (weights, activations)
//             ACCW signed accumulator width, must satisfy ACCW >= 2*DW+1
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   mode                0 = WS, 1 = OS
//   w_in, w_load, w_swap   weight from above, shadow load, active<-shadow swap
//   a_in, a_valid_in    activation from the left and its valid
//   c_in, c_valid_in    partial sum from above, OS drain-chain valid
//   drain, acc_clr      OS accumulator dump, accumulator/ovf clear
//   err_mult, err_mac   fault injection on product / sum bit 0
//   w_out               WS: shadow weight, OS: w_in delayed one cycle
//   a_out, a_valid_out  activation pass-through (one cycle)
//   c_out, c_valid_out  registered partial sum and its valid
//   ovf                 sticky saturation flag
module pe_cell_param #(
  parameter int DW   = 8,
  parameter int ACCW = 24
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   mode,
  input  logic signed [DW-1:0]   w_in,
  input  logic                   w_load,
  input  logic                   w_swap,
  input  logic signed [DW-1:0]   a_in,
  input  logic                   a_valid_in,
  input  logic signed [ACCW-1:0] c_in,
  input  logic                   c_valid_in,
  input  logic                   drain,
  input  logic                   acc_clr,
  input  logic                   err_mult,
  input  logic                   err_mac,
  output logic signed [DW-1:0]   w_out,
  output logic signed [DW-1:0]   a_out,
  output logic                   a_valid_out,
  output logic signed [ACCW-1:0] c_out,
  output logic                   c_valid_out,
  output logic                   ovf
);

  // Clamp limits expressed at the widened ACCW+1 sum width.
  localparam logic signed [ACCW:0] SUM_MAX = {2'b00, {(ACCW-1){1'b1}}};
  localparam logic signed [ACCW:0] SUM_MIN = {2'b11, {(ACCW-1){1'b0}}};

  // True when a widened sum falls outside the representable ACCW range.
  function automatic logic sat_hit_f(input logic signed [ACCW:0] v);
    return (v > SUM_MAX) || (v < SUM_MIN);
  endfunction

  // Clamp a widened sum back into ACCW bits.
  function automatic logic signed [ACCW-1:0] clamp_f(input logic signed [ACCW:0] v);
    logic signed [ACCW-1:0] r;
    if (v > SUM_MAX) begin
      r = SUM_MAX[ACCW-1:0];
    end else if (v < SUM_MIN) begin
      r = SUM_MIN[ACCW-1:0];
    end else begin
      r = v[ACCW-1:0];
    end
    return r;
  endfunction

  // Registers
  logic signed [DW-1:0]   shadow_r, active_r, w_out_r, a_out_r;
  logic signed [ACCW-1:0] acc_r, c_out_r;
  logic                   a_valid_out_r, c_valid_out_r, ovf_r;

  // Combinational datapath and next-state values
  logic signed [DW-1:0]     weight_s;
  logic signed [2*DW-1:0]   prod_raw_s, prod_s;
  logic signed [ACCW-1:0]   prod_ext_s, addend_s, sum_sat_s;
  logic signed [ACCW:0]     sum_wide_s;
  logic                     sat_s;
  logic signed [DW-1:0]     shadow_n_s, active_n_s, w_out_n_s;
  logic signed [ACCW-1:0]   acc_n_s, c_out_n_s;
  logic                     c_valid_n_s, ovf_set_s, ovf_n_s;

  // OS multiplies the streaming weight; WS uses the stationary active weight.
  assign weight_s   = mode ? w_in : active_r;
  // Operands are sign-extended to 2*DW so the product keeps all its bits.
  assign prod_raw_s = $signed({{DW{a_in[DW-1]}}, a_in}) *
                      $signed({{DW{weight_s[DW-1]}}, weight_s});
  assign prod_s     = prod_raw_s ^ {{(2*DW-1){1'b0}}, err_mult};
  assign prod_ext_s = {{(ACCW-2*DW){prod_s[2*DW-1]}}, prod_s};

  // One shared adder: WS adds to c_in, OS adds to the local accumulator.
  assign addend_s   = mode ? acc_r : c_in;
  assign sum_wide_s = {addend_s[ACCW-1], addend_s} + {prod_ext_s[ACCW-1], prod_ext_s};
  assign sat_s      = sat_hit_f(sum_wide_s);
  assign sum_sat_s  = clamp_f(sum_wide_s) ^ {{(ACCW-1){1'b0}}, err_mac};

  // Next-state selection for weights, sum path, accumulator and overflow flag.
  always_comb begin
    shadow_n_s  = shadow_r;
    active_n_s  = active_r;
    w_out_n_s   = w_out_r;
    acc_n_s     = acc_r;
    c_out_n_s   = c_in;
    c_valid_n_s = 1'b0;
    ovf_set_s   = 1'b0;
    ovf_n_s     = ovf_r;

    if (mode == 1'b0) begin
      // Swap reads the pre-load shadow, so load+swap moves old shadow to active.
      if (w_load) begin
        shadow_n_s = w_in;
      end else begin
        shadow_n_s = shadow_r;
      end
      if (w_swap) begin
        active_n_s = shadow_r;
      end else begin
        active_n_s = active_r;
      end
      w_out_n_s = shadow_n_s;
      if (a_valid_in) begin
        c_out_n_s   = sum_sat_s;
        c_valid_n_s = 1'b1;
        ovf_set_s   = sat_s;
      end else begin
        c_out_n_s   = c_in;
        c_valid_n_s = 1'b0;
      end
    end else begin
      w_out_n_s = w_in;
      if (drain) begin
        // Emit the pre-update value and restart from this cycle's product.
        c_out_n_s   = acc_r;
        c_valid_n_s = 1'b1;
        if (a_valid_in) begin
          acc_n_s = prod_ext_s;
        end else begin
          acc_n_s = {ACCW{1'b0}};
        end
      end else begin
        c_out_n_s   = c_in;
        c_valid_n_s = c_valid_in;
        if (a_valid_in) begin
          acc_n_s   = sum_sat_s;
          ovf_set_s = sat_s;
        end else begin
          acc_n_s = acc_r;
        end
      end
    end

    // Clear beats accumulation, drain reload and a same-cycle saturation.
    if (acc_clr) begin
      acc_n_s = {ACCW{1'b0}};
      ovf_n_s = 1'b0;
    end else begin
      ovf_n_s = ovf_r | ovf_set_s;
    end
  end

  // State and output registers; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r      <= {DW{1'b0}};
      active_r      <= {DW{1'b0}};
      w_out_r       <= {DW{1'b0}};
      a_out_r       <= {DW{1'b0}};
      a_valid_out_r <= 1'b0;
      acc_r         <= {ACCW{1'b0}};
      c_out_r       <= {ACCW{1'b0}};
      c_valid_out_r <= 1'b0;
      ovf_r         <= 1'b0;
    end else begin
      shadow_r      <= shadow_n_s;
      active_r      <= active_n_s;
      w_out_r       <= w_out_n_s;
      a_out_r       <= a_in;
      a_valid_out_r <= a_valid_in;
      acc_r         <= acc_n_s;
      c_out_r       <= c_out_n_s;
      c_valid_out_r <= c_valid_n_s;
      ovf_r         <= ovf_n_s;
    end
  end

  assign w_out       = w_out_r;
  assign a_out       = a_out_r;
  assign a_valid_out = a_valid_out_r;
  assign c_out       = c_out_r;
  assign c_valid_out = c_valid_out_r;
  assign ovf         = ovf_r;

endmodule
